mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Command-driven sequencer for the non-pipelined `mac_top` accumulator. It accepts a dot-product command (mode, length) and programs the MAC's `mode` via a `cfg` cycle. It then streams operand pairs from a valid/ready source into the MAC, reads and clears the accumulated result, and returns it on a valid/ready response port. It sits between the operand-fetch logic and `mac_top` and owns every MAC control pin.

## Interface
Parameters:
- `LEN_W`, 8: width of the beat count in a command.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset. `mac_top.rst_n` must be driven by `~rst`.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_mode` in 1: 1 = fp16, 0 = int8.
- `cmd_len` in LEN_W: number of operand pairs, 0 to 2^LEN_W-1.
- `op_valid` in 1, `op_ready` out 1: operand handshake.
- `op_a`, `op_b` in 16: operand pair.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_data` out 16: accumulated result.
- `res_error` out 1: OR of `mac_error` over the command.
- `busy` out 1: state is not IDLE.
- `mac_enable`, `mac_valid`, `mac_read`, `mac_cfg`, `mac_mode` out 1: to `mac_top`.
- `mac_a`, `mac_b` out 16: to `mac_top` `in_a` / `in_b`.
- `mac_out` in 16, `mac_error` in 1: from `mac_top`.

## Operation
- FSM states: IDLE, CFG, RUN, READ, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_mode` and `cmd_len`, clear the beat counter and the error flag, go to CFG.
- CFG (1 cycle):
  - `mac_cfg`=1, `mac_enable`=0, `mac_mode`=latched mode.
  - Next state is RUN if len≠0, else READ.
- RUN:
  - `mac_enable`=1, `op_ready`=1.
  - `mac_valid`=`op_valid`; `mac_a`/`mac_b` pass `op_a`/`op_b` through combinationally.
  - Each handshake increments the counter. On the handshake that makes the counter equal len, go to READ.
  - When `op_valid`=0: `mac_valid`=0 and `mac_read`=0, so the MAC holds its state.
- READ (1 cycle):
  - `mac_enable`=1, `mac_valid`=0, `mac_read`=1.
  - Capture `mac_out` into `res_data` and OR `mac_error` into the error flag. The MAC clears its own registers at the clock edge.
  - Go to RESP.
- RESP:
  - `res_valid`=1; `res_data`/`res_error` are held stable.
  - On `res_ready`, go to IDLE.
- Error flag: the OR of `mac_error` sampled on every RUN handshake cycle and in READ.
- Counter: LEN_W bits wide. Compare for equality before incrementing, so no wrap can occur; len = 2^LEN_W-1 is legal.
- Len=0: no beats. READ returns the cleared accumulator value, 16'h0000.
- Defaults: every `mac_*` output not listed for a state is 0, and `op_ready`=0 outside RUN.
- Reset:
  - FSM goes to IDLE. `res_data`=0, `res_error`=0, `busy`=0, all handshake and `mac_*` outputs 0, counter 0.
  - Reset mid-command discards the command; the MAC is reset by the same signal.

## Timing
- Command accepted at cycle 0 (`cmd_valid`&`cmd_ready`). CFG occupies cycle 1.
- With operands streaming back-to-back, RUN covers cycles 2 to N+1, READ is cycle N+2, and `res_valid` rises at cycle N+3.
- Command-to-result latency is N+3 cycles, plus one cycle per `op_valid` bubble.
- `res_valid` stays high until `res_ready`. IDLE is re-entered the cycle after the response handshake, so back-to-back commands take a 1-cycle gap.
- `cmd_ready`, `op_ready` and `mac_*` are Moore outputs of the state. The exceptions are `mac_valid`, `mac_a` and `mac_b`, which are combinational from `op_*` in RUN.

## Configuration
- Macro: `MAC_SEQ_MODE_CACHE_EN`.
- Defined:
  - A register holds the last programmed mode plus a "programmed" bit; both clear on reset.
  - CFG is skipped (IDLE goes directly to RUN or READ) when the bit is set and `cmd_mode` equals the cached mode. Latency becomes N+2.
  - CFG updates the cache.
- Not defined: every command passes through CFG.

## Test plan
- Int8, len=3, three back-to-back beats of `op_a`=16'h0003, `op_b`=16'h0004:
  - `mac_cfg` pulses at cycle 1.
  - `res_valid` at cycle 6 with `res_data`=16'h0024 and `res_error`=0.
- Fp16, len=2, pairs 16'h3C00 × 16'h4000, with a 3-cycle `op_valid` gap between the beats:
  - `res_data`=16'h4400.
  - `res_valid` at cycle 8; `mac_valid` low during the gap.
- Len=0 in either mode:
  - Sequence is CFG then READ.
  - `res_data`=16'h0000, `res_valid` at cycle 3, `op_ready` never asserted.
- Backpressure: hold `res_ready`=0 for 5 cycles.
  - `res_valid`/`res_data` stay stable and `cmd_ready` stays 0.
  - A second int8 command issued afterwards returns an independent result, proving the accumulator was cleared.
- Assert `rst` mid-RUN, after 2 of 4 beats:
  - All outputs return to reset values immediately.
  - A new len=1 command with 16'h0002 × 16'h0005 returns 16'h000A.
- With `MAC_SEQ_MODE_CACHE_EN`: two consecutive fp16 commands.
  - `mac_cfg` pulses only for the first.
  - The second command's `res_valid` arrives one cycle earlier.
  - A subsequent int8 command pulses `mac_cfg` again.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: command-driven sequencer for the non-pipelined mac_top accumulator.
// A command programs the MAC mode, streams operand pairs into the MAC, then
// reads and clears the result and returns it on a valid/ready response port.
// Optional feature: MAC_SEQ_MODE_CACHE_EN skips the cfg cycle when the MAC
// already holds the requested mode.
module mac_seq_ctrl #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_error,
  output logic             busy,
  output logic             mac_enable,
  output logic             mac_valid,
  output logic             mac_read,
  output logic             mac_cfg,
  output logic             mac_mode,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  input  logic [15:0]      mac_out,
  input  logic             mac_error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CFG  = 3'd1,
    RUN  = 3'd2,
    READ = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             err_q;
  logic [15:0]      res_data_q;
  logic             res_error_q;
  logic             skip_cfg;
  logic             last_beat;

`ifdef MAC_SEQ_MODE_CACHE_EN
  logic cache_mode_q;
  logic cache_vld_q;

  // Cached mode still matches the MAC, so the cfg cycle can be skipped.
  assign skip_cfg = cache_vld_q && (cmd_mode == cache_mode_q);

  // Remember the last mode programmed into the MAC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_mode_q <= 1'b0;
      cache_vld_q  <= 1'b0;
    end else if (state_q == CFG) begin
      cache_mode_q <= mode_q;
      cache_vld_q  <= 1'b1;
    end
  end
`else
  assign skip_cfg = 1'b0;
`endif

  // Counter equals len-1 on the final beat; len is nonzero whenever RUN is entered.
  assign last_beat = (cnt_q == (len_q - LEN_W'(1)));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and Moore outputs; operand path is combinational in RUN.
  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    op_ready   = 1'b0;
    res_valid  = 1'b0;
    mac_enable = 1'b0;
    mac_valid  = 1'b0;
    mac_read   = 1'b0;
    mac_cfg    = 1'b0;
    mac_mode   = 1'b0;
    mac_a      = 16'h0000;
    mac_b      = 16'h0000;
    case (state_q)
      IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid) begin
          if (!skip_cfg) begin
            state_d = CFG;
          end else if (cmd_len != '0) begin
            state_d = RUN;
          end else begin
            state_d = READ;
          end
        end
      end
      CFG: begin
        mac_cfg  = 1'b1;
        mac_mode = mode_q;
        state_d  = (len_q != '0) ? RUN : READ;
      end
      RUN: begin
        mac_enable = 1'b1;
        op_ready   = 1'b1;
        mac_valid  = op_valid;
        mac_a      = op_a;
        mac_b      = op_b;
        if (op_valid && last_beat) begin
          state_d = READ;
        end
      end
      READ: begin
        mac_enable = 1'b1;
        mac_read   = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command latch, beat counter, error accumulation and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      res_data_q  <= 16'h0000;
      res_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            mode_q <= cmd_mode;
            len_q  <= cmd_len;
            cnt_q  <= '0;
            err_q  <= 1'b0;
          end
        end
        RUN: begin
          if (op_valid) begin
            cnt_q <= cnt_q + LEN_W'(1);
            err_q <= err_q | mac_error;
          end
        end
        READ: begin
          res_data_q  <= mac_out;
          res_error_q <= err_q | mac_error;
        end
        default: begin
        end
      endcase
    end
  end

  assign res_data  = res_data_q;
  assign res_error = res_error_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed self-checking bench for mac_seq_ctrl with a
// behavioural mac_top stand-in (int8 and fp16 accumulate, read-and-clear).
// Build with MAC_SEQ_MODE_CACHE_EN defined to exercise the mode cache.
module tb_mac_seq_ctrl;

`ifdef MAC_SEQ_MODE_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_mode;
  logic [7:0]  cmd_len;
  logic        op_valid, op_ready;
  logic [15:0] op_a, op_b;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_error, busy;
  logic        mac_enable, mac_valid, mac_read, mac_cfg, mac_mode;
  logic [15:0] mac_a, mac_b, mac_out;
  logic        mac_error;

  int n_cmp  = 0;
  int n_fail = 0;
  logic err_inj = 1'b0;
  bit   prog = 1'b0;
  bit   last_mode = 1'b0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
    .busy(busy),
    .mac_enable(mac_enable), .mac_valid(mac_valid), .mac_read(mac_read),
    .mac_cfg(mac_cfg), .mac_mode(mac_mode), .mac_a(mac_a), .mac_b(mac_b),
    .mac_out(mac_out), .mac_error(mac_error)
  );

  function automatic real fp16_to_real(input logic [15:0] h);
    real f;
    int  x;
    f = (h[14:10] == 5'd0) ? (real'(h[9:0]) / 1024.0) : (1.0 + real'(h[9:0]) / 1024.0);
    x = (h[14:10] == 5'd0) ? -14 : (int'(h[14:10]) - 15);
    while (x > 0) begin f = f * 2.0; x--; end
    while (x < 0) begin f = f / 2.0; x++; end
    return h[15] ? -f : f;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real v);
    real  r;
    int   e;
    int   m;
    logic s;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    r = s ? -v : v;
    e = 15;
    while (r >= 2.0 && e < 30) begin r = r / 2.0; e++; end
    while (r < 1.0 && e > 1) begin r = r * 2.0; e--; end
    m = $rtoi((r - 1.0) * 1024.0);
    return {s, 5'(e), 10'(m)};
  endfunction

  // Behavioural mac_top: cfg latches mode, valid accumulates, read clears.
  logic [15:0] acc_i;
  real         acc_r;
  logic        smode;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i <= 16'h0000;
      acc_r <= 0.0;
      smode <= 1'b0;
    end else if (mac_cfg) begin
      smode <= mac_mode;
    end else if (mac_enable) begin
      if (mac_read) begin
        acc_i <= 16'h0000;
        acc_r <= 0.0;
      end else if (mac_valid) begin
        acc_i <= acc_i + 16'(int'($signed(mac_a[7:0])) * int'($signed(mac_b[7:0])));
        acc_r <= acc_r + fp16_to_real(mac_a) * fp16_to_real(mac_b);
      end
    end
  end
  assign mac_out   = smode ? real_to_fp16(acc_r) : acc_i;
  assign mac_error = err_inj;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ctl"}, {cmd_ready, op_ready, res_valid, busy, mac_enable, mac_valid,
                        mac_read, mac_cfg, mac_mode, res_error}, 32'h0);
    chk({tag, ".data"}, {res_data, mac_a}, 32'h0);
  endtask

  // One full command; expected cycles are for the path through CFG and are
  // shortened by one when the cache model predicts a skip.
  task automatic do_cmd(input string tag, input bit mode, input int len,
                        input logic [15:0] a, input logic [15:0] b,
                        input int gap, input int hold,
                        input logic [15:0] exp_data, input bit exp_err, input int base_cyc);
    bit          skip;
    int          cyc, beats, gap_left, cfg_cyc, res_cyc;
    bit          cfg_mode, op_seen, gap_bad, hold_bad;
    logic [15:0] d0;
    skip     = CACHE && prog && (mode == last_mode);
    cfg_cyc  = -1;
    res_cyc  = -1;
    cfg_mode = 1'b0;
    op_seen  = 1'b0;
    gap_bad  = 1'b0;
    hold_bad = 1'b0;
    beats    = 0;
    gap_left = 0;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_len   = 8'(len);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'h1);
    tick();
    cmd_valid = 1'b0;
    cyc = 1;
    while (cyc < 600) begin
      if (res_valid) begin
        res_cyc = cyc;
        break;
      end
      if (mac_cfg) begin
        cfg_cyc  = cyc;
        cfg_mode = mac_mode;
      end
      if (op_ready) begin
        op_seen = 1'b1;
        if (beats < len && gap_left == 0) begin
          op_valid = 1'b1;
          op_a = a;
          op_b = b;
        end else begin
          op_valid = 1'b0;
          if (gap_left > 0) gap_left--;
          #1;
          if (mac_valid !== 1'b0) gap_bad = 1'b1;
        end
      end else begin
        op_valid = 1'b0;
      end
      #1;
      if (op_valid) begin
        beats++;
        gap_left = gap;
      end
      tick();
      cyc++;
    end
    op_valid = 1'b0;
    prog = 1'b1;
    last_mode = mode;
    chk({tag, ".res_cyc"}, 32'(res_cyc), 32'(base_cyc - int'(skip)));
    chk({tag, ".cfg_cyc"}, 32'(cfg_cyc), skip ? 32'hFFFF_FFFF : 32'h1);
    if (!skip) chk({tag, ".cfg_mode"}, 32'(cfg_mode), 32'(mode));
    chk({tag, ".op_seen"}, 32'(op_seen), 32'(len != 0));
    chk({tag, ".gap_valid"}, 32'(gap_bad), 32'h0);
    chk({tag, ".res_data"}, 32'(res_data), 32'(exp_data));
    chk({tag, ".res_error"}, 32'(res_error), 32'(exp_err));
    d0 = res_data;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== d0 || cmd_ready !== 1'b0) hold_bad = 1'b1;
    end
    if (hold > 0) chk({tag, ".hold"}, 32'(hold_bad), 32'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, ".idle"}, {29'h0, cmd_ready, busy, res_valid}, 32'h4);
  endtask

  initial begin
    int hs;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_len = 8'h00;
    op_valid = 1'b0; op_a = 16'h0; op_b = 16'h0;
    res_ready = 1'b0;
    tick(); tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk("reset.release", {30'h0, cmd_ready, busy}, 32'h2);

    do_cmd("int8_len3", 1'b0, 3, 16'h0003, 16'h0004, 0, 0, 16'h0024, 1'b0, 6);
    do_cmd("fp16_gap",  1'b1, 2, 16'h3C00, 16'h4000, 3, 0, 16'h4400, 1'b0, 8);
    do_cmd("len0_int8", 1'b0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1'b0, 3);
    do_cmd("len0_fp16", 1'b1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1'b0, 3);
    do_cmd("bp_first",  1'b0, 2, 16'h0007, 16'h0006, 0, 5, 16'h0054, 1'b0, 5);
    do_cmd("bp_second", 1'b0, 1, 16'h00FF, 16'h0002, 0, 0, 16'hFFFE, 1'b0, 4);
    err_inj = 1'b1;
    do_cmd("err_set",   1'b0, 2, 16'h0001, 16'h0001, 0, 0, 16'h0002, 1'b1, 5);
    err_inj = 1'b0;
    do_cmd("err_clear", 1'b1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1'b0, 3);

    // Reset in the middle of RUN after two of four beats.
    cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_len = 8'd4;
    tick();
    cmd_valid = 1'b0;
    op_valid = 1'b1; op_a = 16'h0001; op_b = 16'h0001;
    hs = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      if (op_ready) hs++;
      tick();
    end
    chk("rst_mid.beats", 32'(hs), 32'h2);
    chk("rst_mid.in_run", 32'(op_ready), 32'h1);
    op_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    prog = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    do_cmd("post_rst",  1'b0, 1, 16'h0002, 16'h0005, 0, 0, 16'h000A, 1'b0, 4);

    do_cmd("cache_fp1", 1'b1, 1, 16'h3C00, 16'h4000, 0, 0, 16'h4000, 1'b0, 4);
    do_cmd("cache_fp2", 1'b1, 1, 16'h3C00, 16'h4000, 0, 0, 16'h4000, 1'b0, 4);
    do_cmd("cache_i8",  1'b0, 1, 16'h0003, 16'h0003, 0, 0, 16'h0009, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
